// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Round-robin arbiter for the shared bus mux. It grants one source at a
//   time through a one-hot enable vector and limits how long a source keeps
//   the bus while others wait. It also registers the value seen on the bus
//   during each granted cycle, together with the id of the owner at the time.
//
// Parameters
//   WIDTH     bus data width
//   COUNT     number of bus sources (>= 2)
//   MAX_HOLD  max consecutive grant cycles per owner while others request
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       per-source level request, bit i = source i
//   bus_data  current output of the bus mux
//   enable    one-hot registered grant, all-zero when idle
//   owner     index of the granted source, valid while busy
//   busy      |enable
//   bus_q     bus_data captured on a granted cycle
//   q_owner   owner index that accompanied bus_q
//   q_valid   strobe: bus_q/q_owner were updated on the last edge
//
// Optional feature
//   BUS_ARB_TURNAROUND_EN : when defined, every owner change goes through a
//   one-cycle TURN state with enable=0. When undefined, owner changes are
//   back-to-back with no gap.
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int WIDTH    = 8,
  parameter int COUNT    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [COUNT-1:0]         req,
  input  logic [WIDTH-1:0]         bus_data,
  output logic [COUNT-1:0]         enable,
  output logic [$clog2(COUNT)-1:0] owner,
  output logic                     busy,
  output logic [WIDTH-1:0]         bus_q,
  output logic [$clog2(COUNT)-1:0] q_owner,
  output logic                     q_valid
);

  localparam int IW = $clog2(COUNT);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]    HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [COUNT-1:0] ONE_HOT0 = COUNT'(1);

`ifdef BUS_ARB_TURNAROUND_EN
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  logic [IW-1:0] pending;
`else
  typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

  state_t        state;
  logic [IW-1:0] rr_ptr;      // last granted index, also drives owner
  logic          have_owner;  // clear until the first grant after reset
  logic [HW-1:0] hold;

  logic          idle_found;
  logic [IW-1:0] idle_pick;
  logic          other_found;
  logic [IW-1:0] other_pick;
  logic [IW-1:0] cand;
  int            idle_start;

  assign owner = rr_ptr;
  assign busy  = |enable;

  // Requester search. From IDLE the search includes every source, starting
  // just after the last owner (or at 0 straight out of reset). From GRANT
  // only the other sources are searched, starting after the current owner,
  // so an owner is only ever kept through the hold rules, never re-picked.
  always_comb begin
    idle_found  = 1'b0;
    idle_pick   = '0;
    other_found = 1'b0;
    other_pick  = '0;
    cand        = '0;
    idle_start  = have_owner ? (int'(rr_ptr) + 1) % COUNT : 0;
    for (int i = 0; i < COUNT; i++) begin
      cand = IW'((idle_start + i) % COUNT);
      if (!idle_found && req[cand]) begin
        idle_found = 1'b1;
        idle_pick  = cand;
      end
    end
    for (int i = 1; i < COUNT; i++) begin
      cand = IW'((int'(rr_ptr) + i) % COUNT);
      if (!other_found && req[cand]) begin
        other_found = 1'b1;
        other_pick  = cand;
      end
    end
  end

  // Arbitration FSM and bus capture. The capture uses the busy value from
  // before the edge, so q_valid trails each granted cycle by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      enable     <= '0;
      rr_ptr     <= '0;
      have_owner <= 1'b0;
      hold       <= '0;
      bus_q      <= '0;
      q_owner    <= '0;
      q_valid    <= 1'b0;
`ifdef BUS_ARB_TURNAROUND_EN
      pending    <= '0;
`endif
    end else begin
      if (busy) begin
        bus_q   <= bus_data;
        q_owner <= rr_ptr;
        q_valid <= 1'b1;
      end else begin
        q_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (idle_found) begin
            state      <= GRANT;
            enable     <= ONE_HOT0 << idle_pick;
            rr_ptr     <= idle_pick;
            have_owner <= 1'b1;
            hold       <= HW'(1);
          end
        end

        GRANT: begin
          if (req[rr_ptr] && (!other_found || hold < HOLD_MAX)) begin
            // Keep the owner; the counter saturates once the limit is hit.
            if (hold < HOLD_MAX) begin
              hold <= hold + HW'(1);
            end
          end else if (other_found) begin
`ifdef BUS_ARB_TURNAROUND_EN
            state   <= TURN;
            enable  <= '0;
            pending <= other_pick;
`else
            enable  <= ONE_HOT0 << other_pick;
            rr_ptr  <= other_pick;
            hold    <= HW'(1);
`endif
          end else begin
            state  <= IDLE;
            enable <= '0;
          end
        end

`ifdef BUS_ARB_TURNAROUND_EN
        TURN: begin
          // The next owner was chosen on entry; it is granted unconditionally.
          state  <= GRANT;
          enable <= ONE_HOT0 << pending;
          rr_ptr <= pending;
          hold   <= HW'(1);
        end
`endif

        default: begin
          state  <= IDLE;
          enable <= '0;
        end
      endcase
    end
  end

  // Grant vector is one-hot or empty, and busy mirrors it.
  assert property (@(posedge clk) disable iff (!rst_n)
                   $onehot0(enable) && (busy == |enable));

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed bench for bus_arbiter with WIDTH=8, COUNT=4, MAX_HOLD=4 in the
//   default build (turnaround disabled). Each scenario task drives stimulus
//   and compares outputs against hand-computed values. Inputs change and
//   outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] bus_data;
  logic [3:0] enable;
  logic [1:0] owner;
  logic       busy;
  logic [7:0] bus_q;
  logic [1:0] q_owner;
  logic       q_valid;

  int checks;
  int errors;

  bus_arbiter #(
    .WIDTH    (8),
    .COUNT    (4),
    .MAX_HOLD (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .bus_data (bus_data),
    .enable   (enable),
    .owner    (owner),
    .busy     (busy),
    .bus_q    (bus_q),
    .q_owner  (q_owner),
    .q_valid  (q_valid)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Put the arbiter back into its post-reset state
  task automatic do_reset();
    rst_n    = 1'b0;
    req      = 4'b0000;
    bus_data = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Reset values, first grant after release, and asynchronous mid-grant reset
  task automatic test_reset();
    rst_n    = 1'b0;
    req      = 4'b0000;
    bus_data = 8'h00;
    tick();
    tick();
    checks++; if (enable !== 4'b0000) begin errors++; $display("[TB] FAIL rst_enable: got %b expected 0000", enable); end
    checks++; if (owner !== 2'd0) begin errors++; $display("[TB] FAIL rst_owner: got %0d expected 0", owner); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (bus_q !== 8'h00) begin errors++; $display("[TB] FAIL rst_bus_q: got %h expected 00", bus_q); end
    checks++; if (q_owner !== 2'd0) begin errors++; $display("[TB] FAIL rst_q_owner: got %0d expected 0", q_owner); end
    checks++; if (q_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_q_valid: got %b expected 0", q_valid); end

    rst_n    = 1'b1;
    req      = 4'b1111;
    bus_data = 8'hA5;
    tick();
    checks++; if (enable !== 4'b0001) begin errors++; $display("[TB] FAIL rst_first_grant: got %b expected 0001", enable); end
    tick();
    checks++; if (enable !== 4'b0001) begin errors++; $display("[TB] FAIL rst_hold_grant: got %b expected 0001", enable); end
    checks++; if (q_valid !== 1'b1 || bus_q !== 8'hA5) begin errors++; $display("[TB] FAIL rst_pre_capture: got valid=%b q=%h expected valid=1 q=a5", q_valid, bus_q); end

    // Assert reset between edges; outputs must clear without a clock
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (enable !== 4'b0000) begin errors++; $display("[TB] FAIL rst_async_enable: got %b expected 0000", enable); end
    checks++; if (q_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_q_valid: got %b expected 0", q_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_busy: got %b expected 0", busy); end

    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (enable !== 4'b0001 || owner !== 2'd0) begin errors++; $display("[TB] FAIL rst_regrant: got %b owner %0d expected 0001 owner 0", enable, owner); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  // One source holds its request for 10 cycles with a constant bus value
  task automatic test_single_requester();
    do_reset();
    req      = 4'b0100;
    bus_data = 8'h03;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++; if (enable !== 4'b0100) begin errors++; $display("[TB] FAIL single_enable_c%0d: got %b expected 0100", t, enable); end
      if (t >= 2) begin
        checks++;
        if (q_valid !== 1'b1 || bus_q !== 8'h03 || q_owner !== 2'd2) begin
          errors++;
          $display("[TB] FAIL single_capture_c%0d: got valid=%b q=%h owner=%0d expected valid=1 q=03 owner=2", t, q_valid, bus_q, q_owner);
        end
      end
    end
    req = 4'b0000;
    tick();
    checks++; if (enable !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: got %b busy %b expected 0000 busy 0", enable, busy); end
    checks++; if (q_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_last_strobe: got %b expected 1", q_valid); end
    tick();
    checks++; if (q_valid !== 1'b0 || bus_q !== 8'h03) begin errors++; $display("[TB] FAIL single_q_hold: got valid=%b q=%h expected valid=0 q=03", q_valid, bus_q); end
  endtask

  // All sources request: owners 0,1,2,3,0 for 4 cycles each, no gaps
  task automatic test_round_robin();
    logic [1:0] exp_idx;
    logic [3:0] exp_en;
    do_reset();
    req      = 4'b1111;
    bus_data = 8'h5A;
    for (int t = 1; t <= 20; t++) begin
      tick();
      exp_idx = 2'(((t - 1) / 4) % 4);
      exp_en  = 4'b0001 << exp_idx;
      checks++;
      if (enable !== exp_en || owner !== exp_idx) begin
        errors++;
        $display("[TB] FAIL rr_c%0d: got %b owner %0d expected %b owner %0d", t, enable, owner, exp_en, exp_idx);
      end
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  // Owner release hands over on the next edge, then wrap to 0 and idle
  task automatic test_release_and_wrap();
    do_reset();
    req = 4'b0010;
    tick();
    checks++; if (enable !== 4'b0010) begin errors++; $display("[TB] FAIL rel_grant1: got %b expected 0010", enable); end
    req = 4'b1010;
    tick();
    checks++; if (enable !== 4'b0010) begin errors++; $display("[TB] FAIL rel_keep1: got %b expected 0010", enable); end
    req = 4'b1000;
    tick();
    checks++; if (enable !== 4'b1000 || owner !== 2'd3) begin errors++; $display("[TB] FAIL rel_handover: got %b owner %0d expected 1000 owner 3", enable, owner); end
    req = 4'b0001;
    tick();
    checks++; if (enable !== 4'b0001 || owner !== 2'd0) begin errors++; $display("[TB] FAIL wrap_grant0: got %b owner %0d expected 0001 owner 0", enable, owner); end
    req = 4'b0000;
    tick();
    checks++; if (enable !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL wrap_idle: got %b busy %b expected 0000 busy 0", enable, busy); end
    checks++; if (q_valid !== 1'b1 || q_owner !== 2'd0) begin errors++; $display("[TB] FAIL wrap_q_owner: got valid=%b owner=%0d expected valid=1 owner=0", q_valid, q_owner); end
    tick();
    // From IDLE with last owner 0, the search starts at 1 and finds 3 first
    req = 4'b1001;
    tick();
    checks++; if (enable !== 4'b1000) begin errors++; $display("[TB] FAIL idle_search_order: got %b expected 1000", enable); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  // Random slowly-toggling requests: invariants, capture and starvation bound
  task automatic test_random();
    logic [3:0] cur_req;
    logic [3:0] applied;
    logic       prev_busy;
    logic [7:0] prev_data;
    logic [1:0] prev_owner;
    int         wait_cnt [4];
    int         worst;
    do_reset();
    cur_req = 4'b0000;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7) == 0) cur_req[i] = ~cur_req[i];
      end
      req        = cur_req;
      applied    = cur_req;
      bus_data   = 8'($urandom);
      prev_busy  = busy;
      prev_data  = bus_data;
      prev_owner = owner;
      tick();

      checks++;
      if (!$onehot0(enable) || busy !== |enable) begin
        errors++;
        $display("[TB] FAIL rand_onehot_n%0d: got enable=%b busy=%b expected one-hot-or-zero with matching busy", n, enable, busy);
      end

      checks++;
      if (prev_busy) begin
        if (q_valid !== 1'b1 || bus_q !== prev_data || q_owner !== prev_owner) begin
          errors++;
          $display("[TB] FAIL rand_capture_n%0d: got valid=%b q=%h owner=%0d expected valid=1 q=%h owner=%0d", n, q_valid, bus_q, q_owner, prev_data, prev_owner);
        end
      end else if (q_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rand_capture_n%0d: got valid=%b expected 0", n, q_valid);
      end

      worst = 0;
      for (int i = 0; i < 4; i++) begin
        if (applied[i] && !enable[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > worst) worst = wait_cnt[i];
      end
      checks++;
      if (worst > 12) begin
        errors++;
        $display("[TB] FAIL rand_starvation_n%0d: got wait %0d cycles expected at most 12", n, worst);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  // Scenario sequence and summary
  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    bus_data = 8'h00;
    test_reset();
    test_single_requester();
    test_round_robin();
    test_release_and_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
